// File: rtl/csr_access_unit_if.sv
// csr_access_unit_if: request/response handshake between the core's execute
// stage (master) and csr_access_unit (slave). Data width follows the global
// XLEN macro, which defaults to 32 when the build does not define it.
`ifndef XLEN
`define XLEN 32
`endif

interface csr_access_unit_if;
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [3:0]        req_index;
    logic [`XLEN-1:0]  req_operand;
    logic              resp_valid;
    logic              resp_ready;
    logic [`XLEN-1:0]  resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_op, req_index, req_operand, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_op, req_index, req_operand, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/csr_access_unit.sv
// csr_access_unit: executes one CSR read-write / read-set / read-clear at a
// time. The old value is sampled from the register file's parallel read
// outputs when the request is accepted, a single-cycle write strobe follows,
// and the old value is then returned over the response handshake.
// Optional feature macro CSR_MCYCLE_EN: index 15 maps onto an internal
// free-running cycle counter instead of the register file.
`ifndef XLEN
`define XLEN 32
`endif

module csr_access_unit (
    input  logic                    clk,
    input  logic                    rst,
    csr_access_unit_if.slave        bus,
    input  logic [15:0][`XLEN-1:0]  csr,
    output logic                    wreq,
    output logic [3:0]              windex,
    output logic [`XLEN-1:0]        wdata
);
    localparam int XLEN = `XLEN;

    localparam logic [1:0] OP_ILLEGAL = 2'b00;
    localparam logic [1:0] OP_RS      = 2'b10;
    localparam logic [1:0] OP_RC      = 2'b11;
    localparam logic [3:0] ZERO_INDEX = 4'd0;
`ifdef CSR_MCYCLE_EN
    localparam logic [3:0] MCYCLE_INDEX = 4'd15;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              accept;
    logic [XLEN-1:0]   old_val;
    logic [XLEN-1:0]   new_val;
    logic              suppress;
    logic              hit_counter;

    logic              wreq_q;
    logic [3:0]        windex_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   rdata_q;
    logic              err_q;

`ifdef CSR_MCYCLE_EN
    logic [XLEN-1:0]   mcycle;
    logic              mcycle_load;
`endif

    // State register; reset drops any in-flight request straight back to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the handshake outputs, which depend on state only.
    always_comb begin
        state_next     = state;
        accept         = 1'b0;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    accept     = 1'b1;
                    state_next = WRITE;
                end
            end
            WRITE: begin
                state_next = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                if (bus.resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Old-value sampling, new-value arithmetic and write suppression, all
    // evaluated on the live request so results can be registered on accept.
    always_comb begin
        old_val     = csr[bus.req_index];
        hit_counter = 1'b0;
`ifdef CSR_MCYCLE_EN
        if (bus.req_index == MCYCLE_INDEX) begin
            old_val     = mcycle;
            hit_counter = 1'b1;
        end
`endif
        if (bus.req_index == ZERO_INDEX) begin
            old_val = '0;
        end

        new_val = bus.req_operand;
        case (bus.req_op)
            OP_RS:   new_val = old_val | bus.req_operand;
            OP_RC:   new_val = old_val & ~bus.req_operand;
            default: new_val = bus.req_operand;
        endcase

        suppress = (bus.req_index == ZERO_INDEX)
                || (bus.req_op == OP_ILLEGAL)
                || (((bus.req_op == OP_RS) || (bus.req_op == OP_RC))
                    && (bus.req_operand == '0));
    end

    // Capture write-port values and the response on accept; the strobe is
    // only ever held for the single WRITE cycle that follows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wreq_q   <= 1'b0;
            windex_q <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else if (accept) begin
            wreq_q   <= !suppress && !hit_counter;
            windex_q <= bus.req_index;
            wdata_q  <= new_val;
            rdata_q  <= (bus.req_op == OP_ILLEGAL) ? '0 : old_val;
            err_q    <= (bus.req_op == OP_ILLEGAL);
        end else begin
            wreq_q   <= 1'b0;
        end
    end

`ifdef CSR_MCYCLE_EN
    // Flags a counter load for the WRITE cycle of a non-suppressed index-15 write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcycle_load <= 1'b0;
        end else begin
            mcycle_load <= accept && !suppress && hit_counter;
        end
    end

    // Free-running cycle counter; a load takes priority over the increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcycle <= '0;
        end else if (mcycle_load) begin
            mcycle <= wdata_q;
        end else begin
            mcycle <= mcycle + XLEN'(1);
        end
    end
`endif

    assign wreq           = wreq_q & ~rst;
    assign windex         = windex_q;
    assign wdata          = wdata_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_csr_access_unit.sv
// tb_csr_access_unit: randomized scoreboard bench for csr_access_unit. The
// bench owns a model register file wired to the csr inputs, predicts each
// response and write from its own copy of the CSR contents, and checks them in
// independent response and write monitors.
`timescale 1ns/1ps
`ifndef XLEN
`define XLEN 32
`endif

module tb_csr_access_unit;
    localparam int XLEN = `XLEN;

    typedef struct {
        logic [XLEN-1:0] rdata;
        logic            err;
        int              acc;
    } resp_t;

    typedef struct {
        logic [3:0]      idx;
        logic [XLEN-1:0] data;
        int              acc;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    csr_access_unit_if bus();

    logic [15:0][XLEN-1:0] file;
    logic [15:0][XLEN-1:0] initVals;
    logic                  loadFile = 1'b0;
    logic                  wreq;
    logic [3:0]            windex;
    logic [XLEN-1:0]       wdata;

    csr_access_unit dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .csr    (file),
        .wreq   (wreq),
        .windex (windex),
        .wdata  (wdata)
    );

    int total = 0;
    int bad   = 0;
    int edges = 0;
    int hsEdge = 0;
    bit bpHold = 1'b0;

    logic [XLEN-1:0] refFile [16];
    resp_t respQ[$];
    wr_t   wrQ[$];

`ifdef CSR_MCYCLE_EN
    logic [XLEN-1:0] mcBase = '0;
    int              mcEdge = 0;
`endif

    // Edge counter used to time-stamp accepts, strobes and responses.
    always @(posedge clk) edges <= edges + 1;

    // Register file behind the DUT: preloaded once, then updated by wreq.
    always @(posedge clk) begin
        if (loadFile) file <= initVals;
        else if (wreq) file[windex] <= wdata;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", name, actual, expected);
        end
    endtask

    // Reference model: the CSR rules applied to the bench's own CSR copy.
    task automatic predict(input logic [1:0] op, input logic [3:0] idx,
                           input logic [XLEN-1:0] operand, input int acc);
        logic [XLEN-1:0] old;
        logic [XLEN-1:0] nv;
        bit              isCounter;
        bit              suppress;
        resp_t           r;
        wr_t             w;
        isCounter = 1'b0;
`ifdef CSR_MCYCLE_EN
        isCounter = (idx == 4'd15);
`endif
        if (idx == 4'd0) old = '0;
`ifdef CSR_MCYCLE_EN
        else if (isCounter) old = mcBase + XLEN'(acc - 1 - mcEdge);
`endif
        else old = refFile[idx];
        case (op)
            2'b10:   nv = old | operand;
            2'b11:   nv = old & ~operand;
            default: nv = operand;
        endcase
        suppress = (idx == 4'd0) || (op == 2'b00) || ((op != 2'b01) && (operand == '0));
        r.rdata = (op == 2'b00) ? '0 : old;
        r.err   = (op == 2'b00);
        r.acc   = acc;
        respQ.push_back(r);
        if (!suppress) begin
            if (isCounter) begin
`ifdef CSR_MCYCLE_EN
                mcBase = nv;
                mcEdge = acc + 1;
`endif
            end else begin
                w.idx  = idx;
                w.data = nv;
                w.acc  = acc;
                wrQ.push_back(w);
                refFile[idx] = nv;
            end
        end
    endtask

    // Presents one request, holds it until accepted, and returns the accept edge.
    task automatic applyStimulus(input logic [1:0] op, input logic [3:0] idx,
                                 input logic [XLEN-1:0] operand, input int gap,
                                 input bit doPredict, output int acc);
        bit rdy;
        bit ok;
        int waitCycles;
        repeat (gap) @(negedge clk);
        bus.req_valid   = 1'b1;
        bus.req_op      = op;
        bus.req_index   = idx;
        bus.req_operand = operand;
        ok = 1'b0;
        waitCycles = 0;
        while (!ok && waitCycles < 200) begin
            rdy = bus.req_ready;
            @(posedge clk);
            #1;
            if (rdy) ok = 1'b1;
            else waitCycles++;
        end
        acc = edges;
        bus.req_valid = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("[TB] FAIL req_accept_timeout: got not-accepted want accepted (idx %0d)", idx);
        end else if (doPredict) begin
            predict(op, idx, operand, acc);
        end
    endtask

    task automatic releaseReset();
        @(posedge clk);
        #2;
        rst = 1'b0;
`ifdef CSR_MCYCLE_EN
        mcBase = '0;
        mcEdge = edges;
`endif
    endtask

    // Response monitor: latency, stability under backpressure and data/error checks.
    logic            prevValid = 1'b0;
    logic            prevReady = 1'b0;
    logic [XLEN-1:0] heldData = '0;
    logic            heldErr = 1'b0;
    always @(negedge clk) begin
        resp_t e;
        if (rst) begin
            prevValid = 1'b0;
            prevReady = 1'b0;
        end else begin
            if (prevValid && !prevReady) begin
                checkOutput("resp_valid_held", 64'(bus.resp_valid), 64'(1));
                checkOutput("resp_rdata_stable", 64'(bus.resp_rdata), 64'(heldData));
                checkOutput("resp_err_stable", 64'(bus.resp_err), 64'(heldErr));
            end
            if (bus.resp_valid && !prevValid) begin
                if (respQ.size() == 0) checkOutput("unexpected_resp", 64'(1), 64'(0));
                else checkOutput("resp_latency", 64'(edges), 64'(respQ[0].acc + 1));
            end
            if (bus.resp_valid && bus.resp_ready && respQ.size() != 0) begin
                e = respQ.pop_front();
                checkOutput("resp_rdata", 64'(bus.resp_rdata), 64'(e.rdata));
                checkOutput("resp_err", 64'(bus.resp_err), 64'(e.err));
                hsEdge = edges + 1;
            end
            prevValid = bus.resp_valid;
            prevReady = bus.resp_ready;
            heldData  = bus.resp_rdata;
            heldErr   = bus.resp_err;
        end
    end

    // Write monitor: every strobe must match a predicted write, one cycle after accept.
    logic prevWreq = 1'b0;
    always @(negedge clk) begin
        wr_t w;
        if (rst) begin
            prevWreq = 1'b0;
        end else begin
            if (wreq) begin
                checkOutput("wreq_single_cycle", 64'(prevWreq), 64'(0));
                if (wrQ.size() == 0) begin
                    checkOutput("unexpected_wreq", 64'(windex), 64'(16));
                end else begin
                    w = wrQ.pop_front();
                    checkOutput("wreq_timing", 64'(edges), 64'(w.acc));
                    checkOutput("windex", 64'(windex), 64'(w.idx));
                    checkOutput("wdata", 64'(wdata), 64'(w.data));
                end
            end
            if (wrQ.size() != 0 && edges > wrQ[0].acc) begin
                w = wrQ.pop_front();
                checkOutput("missing_wreq", 64'(0), 64'(1));
            end
            prevWreq = wreq;
        end
    end

    // Core-side response acceptance: random backpressure unless held off.
    initial begin
        bus.resp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            bus.resp_ready = bpHold ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Global time limit so the bench always terminates.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios, random traffic, reset abort and final consistency.
    initial begin
        int acc;
        int accB;
        int w;
        logic [1:0]      rop;
        logic [3:0]      ridx;
        logic [XLEN-1:0] ropnd;

        bus.req_valid   = 1'b0;
        bus.req_op      = 2'b00;
        bus.req_index   = 4'd0;
        bus.req_operand = '0;

        for (int i = 0; i < 16; i++) initVals[i] = XLEN'($urandom);
        initVals[0] = XLEN'($urandom) | XLEN'(1);
        initVals[3] = XLEN'(32'h1234);
        initVals[5] = XLEN'(32'hF0);
        for (int i = 0; i < 16; i++) refFile[i] = initVals[i];

        loadFile = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        loadFile = 1'b0;
        checkOutput("reset_req_ready", 64'(bus.req_ready), 64'(1));
        checkOutput("reset_resp_valid", 64'(bus.resp_valid), 64'(0));
        checkOutput("reset_resp_err", 64'(bus.resp_err), 64'(0));
        checkOutput("reset_resp_rdata", 64'(bus.resp_rdata), 64'(0));
        checkOutput("reset_wreq", 64'(wreq), 64'(0));
        checkOutput("reset_windex", 64'(windex), 64'(0));
        checkOutput("reset_wdata", 64'(wdata), 64'(0));
        releaseReset();

        applyStimulus(2'b01, 4'd3, XLEN'(32'hA5A5_0000), 1, 1'b1, acc);
        applyStimulus(2'b10, 4'd5, XLEN'(32'h0F), 0, 1'b1, acc);
        applyStimulus(2'b11, 4'd5, XLEN'(32'h0F), 0, 1'b1, acc);
        applyStimulus(2'b10, 4'd9, '0, 0, 1'b1, acc);
        applyStimulus(2'b01, 4'd0, XLEN'(32'hDEAD), 1, 1'b1, acc);
        applyStimulus(2'b00, 4'd4, XLEN'(32'h55), 0, 1'b1, acc);
        applyStimulus(2'b01, 4'd6, XLEN'($urandom), 0, 1'b1, acc);
        applyStimulus(2'b10, 4'd6, XLEN'($urandom), 0, 1'b1, acc);

        w = 0;
        while (!bus.req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        bpHold = 1'b1;
        @(posedge clk);
        #3;
        applyStimulus(2'b01, 4'd8, XLEN'($urandom), 0, 1'b1, acc);
        accB = 0;
        fork
            applyStimulus(2'b10, 4'd8, XLEN'($urandom), 0, 1'b1, accB);
        join_none
        w = 0;
        while (!bus.resp_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        checkOutput("bp_resp_arrived", 64'(bus.resp_valid), 64'(1));
        repeat (5) begin
            @(negedge clk);
            checkOutput("bp_resp_valid", 64'(bus.resp_valid), 64'(1));
            checkOutput("bp_req_ready", 64'(bus.req_ready), 64'(0));
        end
        bpHold = 1'b0;
        wait fork;
        checkOutput("bp_accept_after_handshake", 64'(accB > hsEdge - 1), 64'(1));

`ifdef CSR_MCYCLE_EN
        applyStimulus(2'b01, 4'd15, ~XLEN'(1), 0, 1'b1, acc);
        applyStimulus(2'b10, 4'd15, '0, 0, 1'b1, acc);
        applyStimulus(2'b10, 4'd15, '0, 2, 1'b1, acc);
        applyStimulus(2'b11, 4'd15, '0, 3, 1'b1, acc);
`endif

        for (int n = 0; n < 150; n++) begin
            rop   = ($urandom_range(0, 9) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            ridx  = 4'($urandom_range(0, 15));
            ropnd = ($urandom_range(0, 5) == 0) ? '0 : XLEN'($urandom);
            applyStimulus(rop, ridx, ropnd, $urandom_range(0, 2), 1'b1, acc);
        end

        applyStimulus(2'b01, 4'd7, ~refFile[7], 1, 1'b0, acc);
        #1;
        rst = 1'b1;
        respQ.delete();
        wrQ.delete();
        #1;
        checkOutput("abort_wreq", 64'(wreq), 64'(0));
        checkOutput("abort_req_ready", 64'(bus.req_ready), 64'(1));
        checkOutput("abort_resp_valid", 64'(bus.resp_valid), 64'(0));
        checkOutput("abort_resp_err", 64'(bus.resp_err), 64'(0));
        checkOutput("abort_resp_rdata", 64'(bus.resp_rdata), 64'(0));
        checkOutput("abort_windex", 64'(windex), 64'(0));
        checkOutput("abort_wdata", 64'(wdata), 64'(0));
        repeat (2) @(posedge clk);
        releaseReset();
        @(negedge clk);
        checkOutput("abort_no_update", 64'(file[7]), 64'(refFile[7]));

        applyStimulus(2'b01, 4'd7, XLEN'($urandom), 1, 1'b1, acc);
        applyStimulus(2'b11, 4'd7, XLEN'($urandom), 0, 1'b1, acc);

        w = 0;
        while ((respQ.size() != 0 || wrQ.size() != 0) && w < 100) begin
            @(negedge clk);
            w++;
        end
        checkOutput("resp_queue_drained", 64'(respQ.size()), 64'(0));
        checkOutput("write_queue_drained", 64'(wrQ.size()), 64'(0));
        repeat (2) @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("file_%0d", i), 64'(file[i]), 64'(refFile[i]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
